// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings plus the APB PPROT and byte-strobe helpers
// used by the AHB-to-APB bridge.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
    localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

    // Byte lanes touched by an access; the offset is aligned down to the
    // transfer size and wrapped to the bus width (4 or 8 bytes).
    function automatic logic [7:0] apb_pstrb(input logic [2:0]  hsize,
                                             input logic [2:0]  haddr_lsbs,
                                             input int unsigned data_bytes);
        logic [7:0] lanes;
        logic [2:0] align;
        logic [2:0] offs;
        case (hsize)
            HSIZE_BYTE:  begin lanes = 8'h01; align = 3'b111; end
            HSIZE_HWORD: begin lanes = 8'h03; align = 3'b110; end
            HSIZE_WORD:  begin lanes = 8'h0F; align = 3'b100; end
            HSIZE_DWORD: begin lanes = 8'hFF; align = 3'b000; end
            default:     begin lanes = 8'h00; align = 3'b000; end
        endcase
        offs = haddr_lsbs & align;
        if (data_bytes < 8) begin
            offs[2] = 1'b0;
        end
        return lanes << offs;
    endfunction

endpackage

// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite slave to APB4 master bridge: one APB setup/access per accepted
// AHB transfer, with AHB wait states until the completer answers.
module ahb3lite_apb_bridge
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PADDR_SIZE = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [HADDR_SIZE-1:0]   HADDR,
    input  logic [HDATA_SIZE-1:0]   HWDATA,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic [1:0]              HTRANS,
    input  logic                    HMASTLOCK,
    input  logic                    HREADY,
    output logic [HDATA_SIZE-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic [2:0]              PPROT,
    output logic                    PWRITE,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic [HDATA_SIZE-1:0]   PWDATA,
    output logic [HDATA_SIZE/8-1:0] PSTRB,
    input  logic [HDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int         STRB_W   = HDATA_SIZE / 8;
    localparam logic [2:0] SIZE_MAX = (HDATA_SIZE == 64) ? HSIZE_DWORD : HSIZE_WORD;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR1   = 3'd5;
    localparam logic [2:0] ST_ERR2   = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [2:0]            hsize_q;
    logic [HDATA_SIZE-1:0] hrdata_q;
    logic                  hreadyout_q, hresp_q;
    logic                  psel_q, penable_q, pwrite_q;
    logic [2:0]            pprot_q;
    logic [PADDR_SIZE-1:0] paddr_q;
    logic [HDATA_SIZE-1:0] pwdata_q;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic                  accept;
    logic                  unused_inputs;

    assign unused_inputs = &{1'b0, HBURST, HMASTLOCK, HPROT[3:2], HTRANS[0],
                             HADDR[HADDR_SIZE-1:PADDR_SIZE]};

    // New address phases are only taken while the bridge is driving HREADYOUT high.
    assign accept = HSEL && HREADY && HTRANS[1]
                    && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: state_d = accept ? ST_DATA : ST_IDLE;
            ST_DATA:                   state_d = (hsize_q > SIZE_MAX) ? ST_ERR1 : ST_SETUP;
            ST_SETUP:                  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d = PSLVERR ? ST_ERR1 : ST_DONE;
                end
            end
            ST_ERR1:                   state_d = ST_ERR2;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pstrb_d = pwrite_q ? STRB_W'(apb_pstrb(hsize_q, paddr_q[2:0], STRB_W)) : '0;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            hsize_q     <= HSIZE_BYTE;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pprot_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            // Handshake outputs are registered copies of what the next state drives.
            hreadyout_q <= (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
            hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
            psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
            penable_q   <= (state_d == ST_ACCESS);

            if (accept) begin
                paddr_q  <= HADDR[PADDR_SIZE-1:0];
                pwrite_q <= HWRITE;
                hsize_q  <= HSIZE;
                pprot_q  <= {~HPROT[0], 1'b0, HPROT[1]};
            end

            if (state_q == ST_DATA) begin
                pwdata_q <= HWDATA;
                pstrb_q  <= pstrb_d;
            end

            if (state_q == ST_ACCESS && PREADY && !PSLVERR && !pwrite_q) begin
                hrdata_q <= PRDATA;
            end
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PPROT     = pprot_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;

endmodule

// File: doc/ahb3lite_apb_bridge.md
# ahb3lite_apb_bridge

Single-clock AHB3-Lite slave to APB4 master bridge. Sits downstream of the AHB3-Lite interconnect as one slave port and drives a single APB segment whose slaves share HCLK. Converts each accepted AHB transfer into exactly one APB setup/access sequence, inserting AHB wait states until the APB completer responds. Returns a two-cycle AHB ERROR response on PSLVERR or on an unsupported transfer size.

## Interface
- HADDR_SIZE, 32, AHB address width
- HDATA_SIZE, 32, AHB and APB data width; must be 32 or 64
- PADDR_SIZE, 8, APB address width; PADDR = HADDR[PADDR_SIZE-1:0]

Ports:
- HCLK  in  1  sole clock; APB side also runs on HCLK
- HRESETn  in  1  reset, synchronous, active-low
- HSEL, HADDR, HWDATA, HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HTRANS[1:0], HMASTLOCK, HREADY  in  AHB slave inputs; HBURST and HMASTLOCK are ignored
- HRDATA  out  HDATA_SIZE  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- PSEL, PENABLE, PWRITE  out  1  APB control
- PPROT  out  3  {~HPROT[0], 1'b0, HPROT[1]}
- PADDR  out  PADDR_SIZE  APB address
- PWDATA  out  HDATA_SIZE  APB write data
- PSTRB  out  HDATA_SIZE/8  byte strobes; all zero on reads
- PRDATA  in  HDATA_SIZE  APB read data
- PREADY, PSLVERR  in  1  APB completion and error

## Operation
- Transfer is accepted when HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ) holds at a rising edge.
  - Latched on acceptance: HADDR, HWRITE, HSIZE, HPROT.
  - IDLE/BUSY transfers and unselected cycles get a zero-wait OKAY.
- States:
  - IDLE: HREADYOUT=1, HRESP=0, PSEL=0. On accept, go to DATA.
  - DATA: HREADYOUT=0. Capture HWDATA into PWDATA. Compute PSTRB.
    - If HSIZE > log2(HDATA_SIZE/8), go to ERR1 with no APB access.
    - Otherwise go to SETUP.
  - SETUP: PSEL=1, PENABLE=0. Go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Hold while PREADY=0.
    - PREADY & ~PSLVERR: capture PRDATA into HRDATA (reads only), go to DONE.
    - PREADY & PSLVERR: go to ERR1.
  - DONE: PSEL=0, HREADYOUT=1, HRESP=0.
    - Accept: go to DATA (back-to-back transfer).
    - No accept: go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1.
    - Accept: go to DATA.
    - No accept: go to IDLE.
- PSTRB for writes, 32-bit data:
  - byte: 4'b0001 << HADDR[1:0]
  - halfword: 4'b0011 << {HADDR[1],1'b0}
  - word: 4'b1111
  - 64-bit data extends the same rule using HADDR[2:0].
- PADDR, PWRITE, PPROT, PWDATA, PSTRB stay stable from SETUP through the end of ACCESS.
- HRDATA holds its last captured value outside DONE. Writes do not update HRDATA.

## Timing
- All outputs are registered.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0; state IDLE.
- Minimum transfer (PREADY=1 in the first ACCESS cycle):
  - Address phase at cycle 0.
  - DATA at c1, SETUP at c2, ACCESS at c3, DONE at c4.
  - AHB data phase is 4 cycles (3 wait states).
- Each PREADY=0 cycle in ACCESS adds one wait state.
- Error on PSLVERR: ERR1 at c4, ERR2 at c5. HRESP is high in both cycles; HREADYOUT is low then high.
- Back-to-back: an address phase accepted in DONE or ERR2 starts DATA on the next cycle, with no idle APB cycle beyond PSEL=0 in DONE.
- HRESETn low at any edge, including mid-ACCESS: the next state is IDLE with all outputs at reset values. The APB transfer is abandoned.

## Structure
- From ahb3lite_pkg: HTRANS_*, HSIZE_*, HRESP_*.
- Add to ahb3lite_pkg:
  - PPROT bit constants: PPROT_PRIVILEGED=3'b001, PPROT_NONSECURE=3'b010, PPROT_INSTRUCTION=3'b100.
  - Function apb_pstrb(hsize, haddr_lsbs, data_bytes).
- The state enum stays local to the module.
- No sub-module; a single flat module.

## Test plan
- Word write, HADDR=0x24, HWDATA=0xDEADBEEF, PREADY=1 → PSEL at c2, PENABLE at c3, PADDR=0x24, PSTRB=4'b1111, PWDATA=0xDEADBEEF; HREADYOUT low c1–c3, high c4 with HRESP=0.
- Word read, PRDATA=0x12345678, PREADY low for 2 ACCESS cycles → 5 wait states; HRDATA=0x12345678 with HREADYOUT=1; PSTRB=0 throughout.
- Byte write at HADDR=0x03 then halfword write at HADDR=0x02, issued back-to-back → PSTRB=4'b1000, then 4'b1100; second DATA state starts the cycle after the first DONE.
- PSLVERR=1 with PREADY=1 on a read → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); HRDATA unchanged.
- HSIZE=HSIZE_DWORD with HDATA_SIZE=32 → two-cycle ERROR; PSEL never asserted.
- HRESETn low during ACCESS → next edge PSEL=0, PENABLE=0, HREADYOUT=1; an IDLE HTRANS afterwards gets a zero-wait OKAY.
